// File: rtl/rob_pkg.sv
// rob_pkg
//   Shared sizing constants and the entry record for the reorder buffer.
//   DEPTH / PREG_W / DATA_W are the defaults picked up by reorder_buffer's
//   parameters. The entry struct is sized from these constants, so a
//   build that changes the buffer geometry changes it here.
package rob_pkg;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int DATA_W = 32;
    localparam int AREG_W = 5;

    // One in-flight instruction. busy marks an allocated, not yet retired
    // slot; done marks that its result has come back from a functional unit.
    typedef struct packed {
        logic              busy;
        logic              done;
        logic [AREG_W-1:0] dr;
        logic [PREG_W-1:0] drP;
        logic [PREG_W-1:0] oldP;
        logic              regwrite;
        logic [DATA_W-1:0] data;
    } robEntry_t;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order commit buffer between rename and the register file.
//   Rename allocates at the tail, functional units mark entries complete
//   out of order, and the head entry retires (one per cycle) once complete.
//   Retiring an entry also hands its previous physical mapping back to the
//   free list.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   alloc_valid/alloc_ready  allocation handshake from rename
//   alloc_dr/_dr_p/_old_p    architectural dest, new and previous phys tag
//   alloc_regwrite           instruction writes a register
//   alloc_rob_num            slot index given to the presented instruction
//   cmpl_valid/_rob/_data    completion strobe, slot index, result
//   retire_valid             one-cycle commit pulse
//   retire_dr/_dr_p/_data/_regwrite  fields of the committed entry
//   free_valid/free_p        physical tag returned to the free list
//   count                    occupied entries
module reorder_buffer #(
    parameter int DEPTH  = rob_pkg::DEPTH,
    parameter int PREG_W = rob_pkg::PREG_W,
    parameter int DATA_W = rob_pkg::DATA_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [4:0]        alloc_dr,
    input  logic [PREG_W-1:0] alloc_dr_p,
    input  logic [PREG_W-1:0] alloc_old_p,
    input  logic              alloc_regwrite,
    output logic [IDX_W-1:0]  alloc_rob_num,

    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_rob,
    input  logic [DATA_W-1:0] cmpl_data,

    output logic              retire_valid,
    output logic [4:0]        retire_dr,
    output logic [PREG_W-1:0] retire_dr_p,
    output logic [DATA_W-1:0] retire_data,
    output logic              retire_regwrite,

    output logic              free_valid,
    output logic [PREG_W-1:0] free_p,

    output logic [IDX_W:0]    count
);
    import rob_pkg::*;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    logic [IDX_W:0]   headPtr;
    logic [IDX_W:0]   tailPtr;
    logic [IDX_W-1:0] headIdx;
    logic [IDX_W-1:0] tailIdx;

    robEntry_t        robMem [DEPTH];
    robEntry_t        headEntry;
    robEntry_t        newEntry;

    logic             isFull;
    logic             allocFire;
    logic             retireFire;
    logic             cmplHit;

    assign headIdx   = headPtr[IDX_W-1:0];
    assign tailIdx   = tailPtr[IDX_W-1:0];
    assign headEntry = robMem[headIdx];

    // Full comes from registered pointers only: a retire in this same cycle
    // frees a slot for the next cycle, not this one.
    assign isFull        = (headIdx == tailIdx) && (headPtr[IDX_W] != tailPtr[IDX_W]);
    assign alloc_ready   = !isFull;
    assign alloc_rob_num = tailIdx;
    assign allocFire     = alloc_valid && !isFull;

    assign retireFire = headEntry.busy && headEntry.done;

    // A completion only lands on a live entry; if the same slot is being
    // re-allocated this cycle the fresh allocation takes precedence.
    assign cmplHit = cmpl_valid && robMem[cmpl_rob].busy
                     && !(allocFire && (cmpl_rob == tailIdx));

    // Modulo 2*DEPTH subtraction falls out of the pointer width.
    assign count = tailPtr - headPtr;

    always_comb begin
        newEntry          = '0;
        newEntry.busy     = 1'b1;
        newEntry.done     = 1'b0;
        newEntry.dr       = alloc_dr;
        newEntry.drP      = alloc_dr_p;
        newEntry.oldP     = alloc_old_p;
        newEntry.regwrite = alloc_regwrite;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (allocFire)  tailPtr <= tailPtr + 1'b1;
            if (retireFire) headPtr <= headPtr + 1'b1;
        end
    end

    // Entry array. Allocation and retire never address the same slot in one
    // cycle: the retiring head is busy, while an accepted allocation always
    // targets a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) robMem[i] <= '0;
        end else begin
            if (cmplHit) begin
                robMem[cmpl_rob].done <= 1'b1;
                robMem[cmpl_rob].data <= cmpl_data;
            end
            if (retireFire) robMem[headIdx].busy <= 1'b0;
            if (allocFire)  robMem[tailIdx]      <= newEntry;
        end
    end

    // Commit outputs: strobes pulse for one cycle, data fields only update
    // on a retire so consumers can keep sampling the last committed entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid    <= 1'b0;
            retire_dr       <= '0;
            retire_dr_p     <= '0;
            retire_data     <= '0;
            retire_regwrite <= 1'b0;
            free_valid      <= 1'b0;
            free_p          <= '0;
        end else begin
            retire_valid <= retireFire;
            free_valid   <= retireFire && headEntry.regwrite;
            if (retireFire) begin
                retire_dr       <= headEntry.dr;
                retire_dr_p     <= headEntry.drP;
                retire_data     <= headEntry.data;
                retire_regwrite <= headEntry.regwrite;
                free_p          <= headEntry.oldP;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [4:0]        alloc_dr = '0;
    logic [PREG_W-1:0] alloc_dr_p = '0;
    logic [PREG_W-1:0] alloc_old_p = '0;
    logic              alloc_regwrite = 1'b0;
    logic [3:0]        alloc_rob_num;
    logic              cmpl_valid = 1'b0;
    logic [3:0]        cmpl_rob = '0;
    logic [DATA_W-1:0] cmpl_data = '0;
    logic              retire_valid;
    logic [4:0]        retire_dr;
    logic [PREG_W-1:0] retire_dr_p;
    logic [DATA_W-1:0] retire_data;
    logic              retire_regwrite;
    logic              free_valid;
    logic [PREG_W-1:0] free_p;
    logic [4:0]        count;

    reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dr(alloc_dr), .alloc_dr_p(alloc_dr_p), .alloc_old_p(alloc_old_p),
        .alloc_regwrite(alloc_regwrite), .alloc_rob_num(alloc_rob_num),
        .cmpl_valid(cmpl_valid), .cmpl_rob(cmpl_rob), .cmpl_data(cmpl_data),
        .retire_valid(retire_valid), .retire_dr(retire_dr), .retire_dr_p(retire_dr_p),
        .retire_data(retire_data), .retire_regwrite(retire_regwrite),
        .free_valid(free_valid), .free_p(free_p), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        int                idx;
        logic [4:0]        dr;
        logic [PREG_W-1:0] drP;
        logic [PREG_W-1:0] oldP;
        bit                rw;
        bit                done;
        logic [DATA_W-1:0] data;
    } mEnt_t;

    mEnt_t             mq[$];
    int                nextIdx;
    bit                expRv, expFv, expRrw;
    logic [4:0]        expRdr;
    logic [PREG_W-1:0] expRdrP, expFp;
    logic [DATA_W-1:0] expRdata;

    int checks = 0;
    int errors = 0;

    function automatic void modelReset();
        mq.delete();
        nextIdx  = 0;
        expRv    = 0; expFv = 0; expRrw = 0;
        expRdr   = '0; expRdrP = '0; expFp = '0; expRdata = '0;
    endfunction

    // One clock cycle: drive inputs, compare pre-edge state, advance the
    // model, then compare the registered commit outputs after the edge.
    task automatic doCycle(input bit av, input logic [4:0] dr, input logic [PREG_W-1:0] drp,
                           input logic [PREG_W-1:0] oldp, input bit rw, input bit cv,
                           input logic [3:0] crob, input logic [DATA_W-1:0] cdata,
                           output bit accepted);
        bit freeSlot;
        alloc_valid = av; alloc_dr = dr; alloc_dr_p = drp; alloc_old_p = oldp;
        alloc_regwrite = rw; cmpl_valid = cv; cmpl_rob = crob; cmpl_data = cdata;
        #1;
        freeSlot = mq.size() < DEPTH;
        checks++;
        if (alloc_ready !== freeSlot) begin
            errors++; $display("FAIL alloc_ready: got %b expected %b", alloc_ready, freeSlot);
        end
        checks++;
        if (count !== 5'(mq.size())) begin
            errors++; $display("FAIL count: got %0d expected %0d", count, mq.size());
        end
        if (freeSlot) begin
            checks++;
            if (alloc_rob_num !== 4'(nextIdx)) begin
                errors++; $display("FAIL alloc_rob_num: got %0d expected %0d", alloc_rob_num, nextIdx);
            end
        end
        accepted = av && freeSlot;
        // Commit decision uses state from before this edge.
        expRv = 0; expFv = 0;
        if (mq.size() > 0 && mq[0].done) begin
            expRv = 1; expFv = mq[0].rw;
            expRdr = mq[0].dr; expRdrP = mq[0].drP; expRdata = mq[0].data;
            expRrw = mq[0].rw; expFp = mq[0].oldP;
            void'(mq.pop_front());
        end
        if (cv) begin
            foreach (mq[i]) if (mq[i].idx == int'(crob)) begin
                mq[i].done = 1; mq[i].data = cdata;
            end
        end
        if (accepted) begin
            mq.push_back('{idx: nextIdx, dr: dr, drP: drp, oldP: oldp, rw: rw, done: 0, data: '0});
            nextIdx = (nextIdx + 1) % DEPTH;
        end
        @(posedge clk); #1;
        checks++;
        if (retire_valid !== expRv) begin
            errors++; $display("FAIL retire_valid: got %b expected %b", retire_valid, expRv);
        end
        checks++;
        if (free_valid !== expFv) begin
            errors++; $display("FAIL free_valid: got %b expected %b", free_valid, expFv);
        end
        checks++;
        if ({retire_dr, retire_dr_p, retire_data, retire_regwrite, free_p} !==
            {expRdr, expRdrP, expRdata, expRrw, expFp}) begin
            errors++;
            $display("FAIL retire_fields: got dr=%0d drp=%0d data=%h rw=%b fp=%0d expected dr=%0d drp=%0d data=%h rw=%b fp=%0d",
                     retire_dr, retire_dr_p, retire_data, retire_regwrite, free_p,
                     expRdr, expRdrP, expRdata, expRrw, expFp);
        end
    endtask

    task automatic idle(output bit acc);
        doCycle(0, '0, '0, '0, 0, 0, '0, '0, acc);
    endtask

    task automatic allocOne(input int tag, output bit acc);
        logic [4:0] d; logic [PREG_W-1:0] p, o;
        d = 5'($urandom); p = PREG_W'($urandom); o = PREG_W'(tag);
        doCycle(1, d, p, o, 1'($urandom), 0, '0, '0, acc);
    endtask

    task automatic complete(input int idx, input logic [DATA_W-1:0] d, output bit acc);
        doCycle(0, '0, '0, '0, 0, 1, 4'(idx), d, acc);
    endtask

    task automatic doReset();
        alloc_valid = 0; cmpl_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        modelReset();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count, alloc_ready, alloc_rob_num} !== {5'd0, 1'b1, 4'd0}) begin
            errors++; $display("FAIL reset_state: got count=%0d ready=%b num=%0d expected 0/1/0", count, alloc_ready, alloc_rob_num);
        end
        checks++;
        if ({retire_valid, free_valid, retire_data, retire_dr, retire_dr_p, retire_regwrite, free_p} !== '0) begin
            errors++; $display("FAIL reset_outputs: got rv=%b fv=%b data=%h expected all zero", retire_valid, free_valid, retire_data);
        end
        rst = 0;
        modelReset();
    endtask

    task automatic test_fill();
        bit acc;
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (alloc_rob_num !== 4'(i)) begin
                errors++; $display("FAIL fill_index: got %0d expected %0d", alloc_rob_num, i);
            end
            allocOne(i, acc);
        end
        checks++;
        if (count !== 5'd16 || alloc_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: got count=%0d ready=%b expected 16/0", count, alloc_ready);
        end
        allocOne(99, acc);
        checks++;
        if (acc || count !== 5'd16) begin
            errors++; $display("FAIL fill_overflow: got count=%0d expected 16 and no accept", count);
        end
    endtask

    task automatic test_single();
        bit acc;
        doReset();
        doCycle(1, 5'd5, 6'd33, 6'd5, 1, 0, '0, '0, acc);
        complete(0, 32'hDEADBEEF, acc);
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got retire_valid=%b expected 0", retire_valid);
        end
        idle(acc);
        checks++;
        if ({retire_valid, retire_data, free_valid, free_p, retire_dr, retire_dr_p} !==
            {1'b1, 32'hDEADBEEF, 1'b1, 6'd5, 5'd5, 6'd33}) begin
            errors++; $display("FAIL single_retire: got rv=%b data=%h fv=%b fp=%0d expected 1/deadbeef/1/5", retire_valid, retire_data, free_valid, free_p);
        end
        idle(acc);
        checks++;
        if (retire_valid !== 1'b0 || retire_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold: got rv=%b data=%h expected 0/deadbeef", retire_valid, retire_data);
        end
    endtask

    task automatic test_out_of_order();
        bit acc;
        doReset();
        for (int i = 0; i < 3; i++) doCycle(1, 5'(i + 1), 6'(i + 10), 6'(i + 20), 1, 0, '0, '0, acc);
        for (int i = 2; i >= 0; i--) begin
            complete(i, 32'h1000 + 32'(i), acc);
            checks++;
            if (retire_valid !== 1'b0) begin
                errors++; $display("FAIL ooo_early: got retire_valid=%b expected 0 after completing %0d", retire_valid, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            idle(acc);
            checks++;
            if (retire_valid !== 1'b1 || retire_data !== 32'h1000 + 32'(i) || free_p !== 6'(i + 20)) begin
                errors++; $display("FAIL ooo_order: got rv=%b data=%h fp=%0d expected 1/%h/%0d", retire_valid, retire_data, free_p, 32'h1000 + 32'(i), i + 20);
            end
        end
    endtask

    task automatic test_full_retire();
        bit acc;
        doReset();
        for (int i = 0; i < DEPTH; i++) allocOne(i, acc);
        complete(0, 32'hCAFE0000, acc);
        allocOne(40, acc);
        checks++;
        if (acc || retire_valid !== 1'b1) begin
            errors++; $display("FAIL full_same_cycle: got accepted=%b rv=%b expected 0/1", acc, retire_valid);
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_rob_num !== 4'd0) begin
            errors++; $display("FAIL full_reuse_idx: got ready=%b num=%0d expected 1/0", alloc_ready, alloc_rob_num);
        end
        allocOne(41, acc);
        checks++;
        if (!acc || count !== 5'd16) begin
            errors++; $display("FAIL full_next_accept: got accepted=%b count=%0d expected 1/16", acc, count);
        end
    endtask

    task automatic test_wrap();
        bit acc;
        doReset();
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (alloc_rob_num !== 4'(k % DEPTH)) begin
                errors++; $display("FAIL wrap_index: got %0d expected %0d", alloc_rob_num, k % DEPTH);
            end
            allocOne(k, acc);
            complete(k % DEPTH, $urandom, acc);
            idle(acc);
            checks++;
            if (retire_valid !== 1'b1 || count !== 5'd0) begin
                errors++; $display("FAIL wrap_retire: got rv=%b count=%0d expected 1/0 at triple %0d", retire_valid, count, k);
            end
        end
    endtask

    task automatic test_random();
        bit acc, av, cv;
        int crob;
        doReset();
        for (int n = 0; n < 600; n++) begin
            av = ($urandom % 10) < 6;
            cv = ($urandom % 10) < 6;
            if (mq.size() > 0 && ($urandom % 4) != 0) crob = mq[$urandom % mq.size()].idx;
            else crob = $urandom % DEPTH;
            doCycle(av, 5'($urandom), PREG_W'($urandom), PREG_W'($urandom), 1'($urandom),
                    cv, 4'(crob), $urandom, acc);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        doReset();
        for (int i = 0; i < 7; i++) allocOne(i, acc);
        complete(2, 32'h22, acc);
        complete(3, 32'h33, acc);
        rst = 1;
        #1;
        checks++;
        if (count !== 5'd0 || retire_valid !== 1'b0 || alloc_rob_num !== 4'd0) begin
            errors++; $display("FAIL midreset_now: got count=%0d rv=%b num=%0d expected 0/0/0", count, retire_valid, alloc_rob_num);
        end
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (retire_valid !== 1'b0 || count !== 5'd0) begin
                errors++; $display("FAIL midreset_hold: got rv=%b count=%0d expected 0/0", retire_valid, count);
            end
        end
        rst = 0;
        checks++;
        if (alloc_rob_num !== 4'd0) begin
            errors++; $display("FAIL midreset_first_idx: got %0d expected 0", alloc_rob_num);
        end
        allocOne(7, acc);
        complete(0, 32'h77, acc);
        idle(acc);
        checks++;
        if (retire_valid !== 1'b1 || retire_data !== 32'h77) begin
            errors++; $display("FAIL midreset_retire: got rv=%b data=%h expected 1/77", retire_valid, retire_data);
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_fill();
        test_single();
        test_out_of_order();
        test_full_retire();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count (power of two).
REQ-002 Parameter PREG_W, default 6, physical register tag width.
REQ-003 Parameter DATA_W, default 32, result width.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, in, 1, rising-edge clock.
REQ-006 Port rst, in, 1, asynchronous active-high reset.
REQ-007 Port alloc_valid, in, 1, rename presents an instruction.
REQ-008 Port alloc_ready, out, 1, buffer can accept an allocation this cycle.
REQ-009 Port alloc_dr, in, 5, architectural destination.
REQ-010 Port alloc_dr_p, in, PREG_W, newly mapped physical destination.
REQ-011 Port alloc_old_p, in, PREG_W, previous mapping of alloc_dr.
REQ-012 Port alloc_regwrite, in, 1, instruction writes a register.
REQ-013 Port alloc_rob_num, out, log2(DEPTH), index assigned to the presented instruction.
REQ-014 Port cmpl_valid, in, 1, functional unit completion strobe.
REQ-015 Port cmpl_rob, in, log2(DEPTH), completing entry index.
REQ-016 Port cmpl_data, in, DATA_W, completion result.
REQ-017 Port retire_valid, out, 1, one-cycle commit pulse.
REQ-018 Ports retire_dr (5), retire_dr_p (PREG_W), retire_data (DATA_W), retire_regwrite (1), all out: committed entry fields.
REQ-019 Port free_valid, out, 1, returns one tag to the free list.
REQ-020 Port free_p, out, PREG_W, tag being freed.
REQ-021 Port count, out, log2(DEPTH)+1, occupied entries.

Function
REQ-022 Circular buffer; head and tail pointers are log2(DEPTH)+1 bits wide, with the MSB as the wrap bit; empty when head==tail, full when indices are equal and wrap bits differ.
REQ-023 alloc_ready = !full, derived from registered state only; a same-cycle retire does not unblock a full buffer.
REQ-024 alloc_rob_num = tail index, combinational, valid whenever alloc_ready is high.
REQ-025 On alloc_valid && alloc_ready, the entry at tail is written with busy=1 and done=0, and tail increments modulo 2*DEPTH.
REQ-026 On cmpl_valid, if entry cmpl_rob is busy, set done=1 and store cmpl_data; a completion to a non-busy entry is ignored.
REQ-027 If a completion and an allocation target the same index in one cycle, the allocation wins and done=0.
REQ-028 Retire is in order, at most one per cycle; at an edge where the head entry has busy && done, clear busy, increment head, and register the retire_* outputs with retire_valid=1 for one cycle.
REQ-029 Latency: completion sampled at edge N gives retire_valid high after edge N+1, at the earliest.
REQ-030 free_valid = retire_valid && retire_regwrite; free_p = the committed entry's old_p, registered alongside the retire outputs.
REQ-031 When retire_valid=0, the retire_* and free_* data outputs hold their previous values.
REQ-032 Simultaneous allocate and retire leaves count unchanged; both pointers advance.
REQ-033 count = tail - head, computed modulo 2*DEPTH.

Reset
REQ-034 While rst is high: head=tail=0, all busy=0 and done=0, retire_valid=0, free_valid=0, and all data outputs are 0.
REQ-035 Reset asserted mid-operation discards all entries immediately; the first allocation after release receives index 0.

Structure
REQ-036 Package rob_pkg holds DEPTH, PREG_W, DATA_W, and the entry struct (busy, done, dr, dr_p, old_p, regwrite, data).
REQ-037 There is no sub-module; pointer logic and the entry array are inline.

Verification
REQ-038 Reset, then allocate 16 entries with no completions: alloc_rob_num runs 0..15, count=16, alloc_ready=0, and a 17th alloc_valid is not accepted.
REQ-039 Allocate idx0 (dr=5, dr_p=33, old_p=5, regwrite=1), complete idx0 with 0xDEADBEEF: one cycle later retire_valid=1, retire_data=0xDEADBEEF, free_valid=1, free_p=5.
REQ-040 Allocate 0,1,2 and complete in order 2,1,0: no retire until idx0 completes, then three consecutive retire pulses for 0,1,2.
REQ-041 With the buffer full and the head done, assert alloc_valid: retire occurs, allocation is refused that cycle and accepted the next, and the new index equals the old head index.
REQ-042 Wrap-around: run 40 allocate/complete/retire triples; indices wrap 15->0, count never exceeds 16, and the wrap bit toggles correctly.
REQ-043 Assert rst with 7 entries pending: count=0 immediately and no retire pulses; the next allocation receives index 0.
